rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
- Upstream sequencer for the single-port ROM (sprom). On a start command it generates a burst of ROM read addresses from a base address and word count.
- It absorbs the ROM's read latency and presents the returned words as a valid/ready stream, with full backpressure support.
- It sits between a control/command block and any streaming consumer, with the ROM hanging off its rom_addr/rom_q pins.

Parameters:
- DWIDTH, 128: ROM word width; must match the ROM instance.
- AWIDTH, 2: ROM address width; depth = 2^AWIDTH.
- ROM_LAT, 1: ROM read latency in cycles. 1 pairs with a registered-output ROM; 0 pairs with a combinational-output ROM. Only 0 and 1 are legal.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle command strobe; sampled only in IDLE
- base_addr  in  AWIDTH  first word address; sampled with start
- len  in  AWIDTH+1  number of words, 0..2^AWIDTH; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at burst completion
- rom_addr  out  AWIDTH  address to ROM
- rom_q  in  DWIDTH  ROM read data, valid ROM_LAT cycles after rom_addr
- m_data  out  DWIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  marks the final beat of a burst

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, rom_addr=0. All internal counters and in-flight flags clear; state=IDLE.
- States and transitions:
  - IDLE -> READ when start=1 and len!=0.
  - IDLE -> FINISH when start=1 and len=0; done pulses the next cycle and no beats are produced.
  - READ: issues addresses. After the last address is issued, wait for the output buffer to drain.
  - READ -> FINISH in the cycle the m_last beat handshakes (m_valid & m_ready).
  - FINISH: done=1 and busy=0 for exactly one cycle -> IDLE.
- start outside IDLE (READ or FINISH) is ignored; base_addr and len are not resampled.
- Address generation:
  - rom_addr is a register. It loads base_addr at start and increments by 1 on each issue.
  - It wraps modulo 2^AWIDTH (e.g. AWIDTH=4: 15 -> 0).
  - A remaining-issue counter (AWIDTH+1 bits) loads len and decrements on each issue.
  - rom_addr holds its value when not issuing.
- Issue rule: in READ with remaining>0, issue when (buffer occupancy + in-flight reads − pop_this_cycle) < 2.
  - An issue in cycle c means rom_addr is valid in cycle c.
- Data capture:
  - A ROM_LAT-deep valid shift register tags in-flight reads.
  - rom_q is written into the buffer in cycle c+ROM_LAT.
  - The final written beat carries the last flag.
- Output buffer:
  - 2-entry FIFO with registered outputs; a word written in cycle w is visible on m_data/m_valid in cycle w+1.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - Simultaneous push and pop is allowed; the buffer never overflows, guaranteed by the credit rule.
- Latency and throughput (start sampled at cycle 0):
  - First address is issued at cycle 1.
  - First m_valid is at cycle 2+ROM_LAT.
  - With m_ready held at 1, one beat per cycle follows with no bubbles, for both ROM_LAT values.
- Completion: done pulses in the cycle after the m_last handshake, and busy falls in that same cycle.
- Reset mid-burst: state returns to IDLE next cycle with all outputs at reset values. In-flight ROM data is discarded and no stale beat appears after reset.

Test Plan:
- Full-rate burst: AWIDTH=4, ROM_LAT=1, mem[i]=i, base_addr=3, len=5, m_ready=1.
  - Required: m_data 3,4,5,6,7 on cycles 3–7; m_last only with 7; done=1 at cycle 8; busy high cycles 1–7.
- Wrap-around: base_addr=14, len=4.
  - Required: beats 14,15,0,1 and rom_addr sequence 14,15,0,1.
  - Repeat with ROM_LAT=0: first m_valid at cycle 2.
- Backpressure: base_addr=0, len=8, m_ready pattern 1,0,0,1,0,1...
  - Required: exactly beats 0..7 in order, with no drop and no duplicate.
  - m_data stable during every stall; buffer occupancy never exceeds 2.
- Zero length: len=0.
  - Required: done pulse at cycle 1; m_valid never asserts; busy stays 0.
- Full depth and ignored start: base_addr=5, len=16.
  - Required: 16 beats 5..15,0..4.
  - A start pulse at cycle 4 with base_addr=9 is ignored; only one done occurs.
- Reset mid-burst: assert rst at cycle 4 of a len=10 burst.
  - Required: next cycle m_valid=0, busy=0, rom_addr=0; no beat emitted afterwards.
  - A new start with base_addr=2, len=2 then yields beats 2,3.

Source files
------------

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: burst ROM address sequencer presenting read data as a valid/ready stream
module rom_stream_reader #(
  parameter int DWIDTH  = 128,
  parameter int AWIDTH  = 2,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_q,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH:0] rem_q, rem_d;
  logic [1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic l0_q, l0_d, l1_q, l1_d;
  logic load, issue, issue_last, infl, push, push_last, pop, hd_ld, s1_ld;

  assign m_valid  = cnt_q != 2'd0;
  assign m_data   = d0_q;
  assign m_last   = l0_q & m_valid;
  assign rom_addr = addr_q;
  assign pop      = m_valid & m_ready;
  assign load     = state_q == IDLE && start;
  // A read may issue only if its word is guaranteed a free buffer slot on arrival
  assign issue      = state_q == READ && rem_q != '0 &&
                      ({1'b0, cnt_q} + {2'b0, infl} < 3'd2 + {2'b0, pop});
  assign issue_last = issue && rem_q == {{AWIDTH{1'b0}}, 1'b1};

  // Tag in-flight reads so returning words are captured in the right cycle
  if (ROM_LAT == 0) begin : g_comb
    assign infl      = 1'b0;
    assign push      = issue;
    assign push_last = issue_last;
  end else begin : g_reg
    logic vld_q, lst_q;
    // Track the single outstanding read of a registered-output ROM
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        lst_q <= 1'b0;
      end else begin
        vld_q <= issue;
        lst_q <= issue_last;
      end
    end
    assign infl      = vld_q;
    assign push      = vld_q;
    assign push_last = lst_q;
  end

  // State register
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    state_d = load ? (len == '0 ? FINISH : READ) :
              (state_q == READ && pop && m_last) ? FINISH :
              (state_q == FINISH) ? IDLE : state_q;
  end

  // Status outputs decoded from state
  always_comb begin
    busy = state_q == READ;
    done = state_q == FINISH;
  end

  // Address/counter and two-entry output buffer next-state
  always_comb begin
    addr_d = load ? base_addr : issue ? addr_q + 1'b1 : addr_q;
    rem_d  = load ? len : issue ? rem_q - 1'b1 : rem_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    hd_ld  = (cnt_q == 2'd0 && push) || (pop && (cnt_q == 2'd2 || push));
    s1_ld  = push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop));
    d0_d   = hd_ld ? (cnt_q == 2'd2 ? d1_q : rom_q) : d0_q;
    l0_d   = hd_ld ? (cnt_q == 2'd2 ? l1_q : push_last) : l0_q;
    d1_d   = s1_ld ? rom_q : d1_q;
    l1_d   = s1_ld ? push_last : l1_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      d0_q   <= '0;
      d1_q   <= '0;
      l0_q   <= 1'b0;
      l1_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      l0_q   <= l0_d;
      l1_q   <= l1_d;
    end
  end
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: checks both ROM latencies against a burst scoreboard and table of bursts
module tb_rom_stream_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b1, en = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] len = '0;
  logic [1:0][15:0] md;
  logic [1:0][3:0] ra;
  logic [1:0] mv, ml, bz, dn;
  logic [15:0] q0, q1;
  int total = 0, pass = 0;

  always #5 clk = ~clk;

  assign q0 = {12'h0, ra[0]};
  always @(posedge clk) q1 <= {12'h0, ra[1]};

  rom_stream_reader #(.DWIDTH(16), .AWIDTH(4), .ROM_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(bz[0]), .done(dn[0]), .rom_addr(ra[0]), .rom_q(q0),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready), .m_last(ml[0]));
  rom_stream_reader #(.DWIDTH(16), .AWIDTH(4), .ROM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(bz[1]), .done(dn[1]), .rom_addr(ra[1]), .rom_q(q1),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready), .m_last(ml[1]));

  task automatic chk(input string n, input int k, input longint a, input longint e);
    total++;
    if (a == e) pass++;
    else $display("FAIL %s lat%0d: got %0d expected %0d", n, k, a, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard model: a burst is a list of words (base+i) mod 16, last on the final one
  logic [16:0] sb [2][64];
  int wp [2], rp [2], ph [2];
  logic [1:0] stall;
  logic [15:0] sd [2];
  initial begin
    for (int k = 0; k < 2; k++) begin wp[k] = 0; rp[k] = 0; ph[k] = 0; end
    stall = '0;
    forever begin
      @(negedge clk);
      if (en) begin
        for (int k = 0; k < 2; k++) begin
          logic [16:0] e;
          logic hs_last;
          hs_last = 1'b0;
          chk("busy", k, bz[k], ph[k] == 1);
          chk("done", k, dn[k], ph[k] == 2);
          if (stall[k]) begin
            chk("stall_valid", k, mv[k], 1);
            chk("stall_data", k, md[k], sd[k]);
          end
          if (mv[k]) begin
            chk("beat_expected", k, wp[k] != rp[k], 1);
            if (wp[k] != rp[k]) begin
              e = sb[k][rp[k] % 64];
              chk("beat_data", k, md[k], e[15:0]);
              chk("beat_last", k, ml[k], e[16]);
              if (m_ready) begin
                hs_last = e[16];
                rp[k]++;
              end
            end
          end
          stall[k] = mv[k] & ~m_ready & ~rst;
          sd[k] = md[k];
          if (rst) begin
            ph[k] = 0;
            rp[k] = wp[k];
            stall[k] = 1'b0;
          end else if (ph[k] == 0 && start) begin
            for (int i = 0; i < int'(len); i++) begin
              sb[k][wp[k] % 64] = {i == int'(len) - 1, 16'((int'(base_addr) + i) % 16)};
              wp[k]++;
            end
            ph[k] = (len == 0) ? 2 : 1;
          end else if (ph[k] == 1 && hs_last) ph[k] = 2;
          else if (ph[k] == 2) ph[k] = 0;
        end
      end
    end
  end

  int nb [2], fd [2], ld [2], dc [2], fv [2], nd [2];
  int ra_s [2][4];
  int pat [6] = '{1, 0, 0, 1, 0, 1};

  // Start a burst at relative cycle 0 and observe both DUTs until both finish
  task automatic run_burst(input int b, input int l, input int mode, input int ig);
    bit fin;
    int mx;
    fin = 0;
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; fd[k] = -1; ld[k] = -1; dc[k] = -1; fv[k] = -1; nd[k] = 0;
    end
    start = 1'b1; base_addr = 4'(b); len = 5'(l);
    for (int r = 0; r < 300 && !fin; r++) begin
      if (r > 0) begin
        start = (r == ig);
        if (r == ig) begin base_addr = 4'd9; len = 5'd3; end
      end
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[r % 6][0] : 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        if (mv[k] && fv[k] < 0) fv[k] = r;
        if (mv[k] && m_ready) begin
          nb[k]++;
          if (fd[k] < 0) fd[k] = int'(md[k]);
          ld[k] = int'(md[k]);
        end
        if (dn[k]) begin
          nd[k]++;
          if (dc[k] < 0) dc[k] = r;
        end
        if (r >= 1 && r <= 4) ra_s[k][r-1] = int'(ra[k]);
      end
      mx = dc[0] > dc[1] ? dc[0] : dc[1];
      if (dc[0] >= 0 && dc[1] >= 0 && r >= mx + 1) fin = 1;
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 2; k++) if (dc[k] < 0) chk("done_timeout", k, dc[k], 0);
  endtask

  typedef struct {int b; int l; int mode; int first; int last; int fv1; int dn1;} vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{3, 5, 0, 3, 7, 3, 8};
    tbl[1] = '{14, 4, 0, 14, 1, 3, 7};
    tbl[2] = '{0, 8, 1, 0, 7, 3, -1};
    tbl[3] = '{6, 0, 0, 0, 0, -1, 1};
    tbl[4] = '{5, 16, 0, 5, 4, 3, 19};
    tbl[5] = '{9, 1, 2, 9, 9, 3, -1};
    tbl[6] = '{15, 2, 0, 15, 0, 3, 5};
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, mv[k], 0);
      chk("rst_last", k, ml[k], 0);
      chk("rst_busy", k, bz[k], 0);
      chk("rst_done", k, dn[k], 0);
      chk("rst_data", k, md[k], 0);
      chk("rst_addr", k, ra[k], 0);
    end
    rst = 1'b0;
    en = 1'b1;
    tick();
    foreach (tbl[t]) begin
      run_burst(tbl[t].b, tbl[t].l, tbl[t].mode, -1);
      for (int k = 0; k < 2; k++) begin
        chk("tbl_beats", k, nb[k], tbl[t].l);
        chk("tbl_first_valid", k, fv[k], tbl[t].fv1 < 0 ? -1 : tbl[t].fv1 - 1 + k);
        if (tbl[t].l > 0) begin
          chk("tbl_first", k, fd[k], tbl[t].first);
          chk("tbl_last", k, ld[k], tbl[t].last);
        end
        if (tbl[t].dn1 >= 0) chk("tbl_done_cycle", k, dc[k], tbl[t].l == 0 ? tbl[t].dn1 : tbl[t].dn1 - 1 + k);
      end
    end
    run_burst(14, 4, 0, -1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) chk("wrap_addr", k, ra_s[k][i], (14 + i) % 16);
    run_burst(5, 16, 0, 4);
    for (int k = 0; k < 2; k++) begin
      chk("ign_beats", k, nb[k], 16);
      chk("ign_done_count", k, nd[k], 1);
      chk("ign_last", k, ld[k], 4);
    end
    m_ready = 1'b1;
    start = 1'b1; base_addr = 4'd0; len = 5'd10;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_valid", k, mv[k], 0);
      chk("mid_rst_busy", k, bz[k], 0);
      chk("mid_rst_addr", k, ra[k], 0);
      chk("mid_rst_last", k, ml[k], 0);
    end
    repeat (5) tick();
    run_burst(2, 2, 0, -1);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_beats", k, nb[k], 2);
      chk("post_rst_first", k, fd[k], 2);
      chk("post_rst_last", k, ld[k], 3);
    end
    for (int n = 0; n < 25; n++) begin
      int b, l;
      b = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 16));
      run_burst(b, l, 2, -1);
      for (int k = 0; k < 2; k++) begin
        chk("rnd_beats", k, nb[k], l);
        chk("rnd_first_valid", k, fv[k], l == 0 ? -1 : 2 + k);
        if (l > 0) begin
          chk("rnd_first", k, fd[k], b);
          chk("rnd_last", k, ld[k], (b + l - 1) % 16);
        end
      end
    end
    repeat (3) tick();
    for (int k = 0; k < 2; k++) chk("sb_drained", k, wp[k] - rp[k], 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
